// File: rtl/hazard_scoreboard.sv
// Purpose: tracks in-flight destination registers, requests ID stalls and produces forwarding selects.
// Latency: stall is combinational (0 cycles); fwd_sel is registered and valid in the consumer's EX cycle.
// Backpressure: stall holds PC and IF/ID and inserts a bubble; enable=0 freezes all state.
//
// Ports:
//   clk, srst (sync active-high)   clock and reset
//   enable                         global advance
//   issue_*                        instruction currently in ID (valid, rd, reg_write, load)
//   src_addr / src_used            packed source addresses, source s at [s*REG_ADDR_W +: REG_ADDR_W]
//   flush                          squash ID and the FLUSH_SLOTS youngest in-flight slots
//   stall                          combinational stall request for ID
//   fwd_sel                        per-source select, 0 = register file, j+1 = result held in slot j
//   stall_cnt                      saturating count of stalled cycles
module hazard_scoreboard #(
    parameter int REG_ADDR_W  = 5,
    parameter int NUM_SRC     = 2,
    parameter int DEPTH       = 3,
    parameter int ALU_LAT     = 1,
    parameter int LOAD_LAT    = 2,
    parameter int FLUSH_SLOTS = 1,
    parameter int SEL_W       = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic                          enable,
    input  logic                          issue_valid,
    input  logic [REG_ADDR_W-1:0]         issue_rd,
    input  logic                          issue_reg_write,
    input  logic                          issue_mem_read,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]            src_used,
    input  logic                          flush,
    output logic                          stall,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic [31:0]                   stall_cnt
);

    // Slot 0 is EX, slot 1 is MEM, and so on.
    logic [DEPTH-1:0]                 slot_valid;
    logic [DEPTH-1:0]                 slot_is_load;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] slot_rd;

    logic [NUM_SRC-1:0][SEL_W-1:0]    sel_next;
    logic [NUM_SRC-1:0][SEL_W-1:0]    fwd_sel_q;
    logic [NUM_SRC-1:0]               src_unready;

    logic [REG_ADDR_W-1:0]            cur_addr;
    logic                             hit;
    logic                             hit_load;
    int                               hit_k;
    int                               lat;
    logic                             insert;

    always_comb begin
        sel_next    = '0;
        src_unready = '0;
        cur_addr    = '0;
        hit         = 1'b0;
        hit_load    = 1'b0;
        hit_k       = 0;
        lat         = 0;
        for (int s = 0; s < NUM_SRC; s++) begin
            cur_addr = src_addr[s*REG_ADDR_W +: REG_ADDR_W];
            hit      = 1'b0;
            hit_load = 1'b0;
            hit_k    = 0;
            // Scan oldest to youngest so the youngest match overwrites older ones.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (slot_valid[k] && (slot_rd[k] == cur_addr)) begin
                    hit      = 1'b1;
                    hit_load = slot_is_load[k];
                    hit_k    = k;
                end
            end
            lat = hit_load ? LOAD_LAT : ALU_LAT;
            if (src_used[s] && (cur_addr != '0) && hit) begin
                // When the consumer reaches EX the producer sits in slot hit_k+1.
                if (hit_k + 1 >= DEPTH) begin
                    sel_next[s] = '0;   // retired: register file write-through covers it
                end else if (hit_k + 1 >= lat) begin
                    sel_next[s] = SEL_W'(hit_k + 2);
                end else begin
                    src_unready[s] = 1'b1;
                end
            end
        end
    end

    assign stall   = issue_valid && (|src_unready) && !flush;
    assign insert  = issue_valid && !stall && !flush;
    assign fwd_sel = fwd_sel_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            slot_valid   <= '0;
            slot_is_load <= '0;
            slot_rd      <= '0;
            fwd_sel_q    <= '0;
            stall_cnt    <= '0;
        end else if (enable) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                // A taken branch kills the youngest FLUSH_SLOTS instructions as they advance.
                slot_valid[k]   <= slot_valid[k-1] && !(flush && (k <= FLUSH_SLOTS));
                slot_rd[k]      <= slot_rd[k-1];
                slot_is_load[k] <= slot_is_load[k-1];
            end
            slot_valid[0]   <= insert && issue_reg_write && (issue_rd != '0);
            slot_rd[0]      <= issue_rd;
            slot_is_load[0] <= issue_mem_read;
            fwd_sel_q       <= insert ? sel_next : '0;
            if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Purpose: checks two scoreboard configurations (defaults, and DEPTH=5/LOAD_LAT=3) against a queue model.
// Latency: stall compared mid-cycle, fwd_sel and stall_cnt compared 1 time unit after each edge.
// Backpressure: the bench holds ID inputs while the model predicts a stall.
module tb_hazard_scoreboard;
    localparam int RW  = 5;
    localparam int NS  = 2;
    localparam int SWA = 2;
    localparam int SWB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              srst = 1'b1;
    logic              enable = 1'b1;
    logic              issue_valid = 1'b0;
    logic [RW-1:0]     issue_rd = '0;
    logic              issue_reg_write = 1'b0;
    logic              issue_mem_read = 1'b0;
    logic [NS*RW-1:0]  src_addr = '0;
    logic [NS-1:0]     src_used = '0;
    logic              flush = 1'b0;

    logic              stall_a, stall_b;
    logic [NS*SWA-1:0] fwd_sel_a;
    logic [NS*SWB-1:0] fwd_sel_b;
    logic [31:0]       cnt_a, cnt_b;

    hazard_scoreboard dut_a (
        .clk(clk), .srst(srst), .enable(enable), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .issue_reg_write(issue_reg_write), .issue_mem_read(issue_mem_read),
        .src_addr(src_addr), .src_used(src_used), .flush(flush),
        .stall(stall_a), .fwd_sel(fwd_sel_a), .stall_cnt(cnt_a)
    );

    hazard_scoreboard #(.DEPTH(5), .LOAD_LAT(3)) dut_b (
        .clk(clk), .srst(srst), .enable(enable), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .issue_reg_write(issue_reg_write), .issue_mem_read(issue_mem_read),
        .src_addr(src_addr), .src_used(src_used), .flush(flush),
        .stall(stall_b), .fwd_sel(fwd_sel_b), .stall_cnt(cnt_b)
    );

    // Reference model: per configuration, a list of in-flight instructions ordered by age.
    typedef struct {
        bit v;
        int rd;
        bit ld;
    } ent_t;

    int      md[2] = '{3, 5};
    int      ml[2] = '{2, 3};
    ent_t    mq[2][8];
    int      m_sel_c[2][NS];
    int      m_sel_q[2][NS];
    bit      m_st[2];
    longint  m_cnt[2];

    int checks = 0;
    int failures = 0;
    bit last_stall_a, last_stall_b;

    task automatic chk(string tag, longint obs, longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void mreset(int m);
        for (int i = 0; i < 8; i++) mq[m][i] = '{0, 0, 0};
        for (int s = 0; s < NS; s++) m_sel_q[m][s] = 0;
        m_cnt[m] = 0;
    endfunction

    // Producer found at age a reaches age a+1 when the consumer is in EX; it must have produced by then.
    function automatic void mcompute(int m);
        bit any_wait = 0;
        for (int s = 0; s < NS; s++) begin
            int addr = int'(src_addr[s*RW +: RW]);
            int age = -1;
            m_sel_c[m][s] = 0;
            if (src_used[s] && addr != 0) begin
                for (int i = md[m] - 1; i >= 0; i--)
                    if (mq[m][i].v && mq[m][i].rd == addr) age = i;
                if (age >= 0) begin
                    int need = mq[m][age].ld ? ml[m] : 1;
                    if (age + 1 >= md[m]) m_sel_c[m][s] = 0;
                    else if (age + 1 >= need) m_sel_c[m][s] = age + 2;
                    else any_wait = 1;
                end
            end
        end
        m_st[m] = issue_valid && any_wait && !flush;
    endfunction

    function automatic void mstep(int m);
        bit ins;
        if (srst) begin
            mreset(m);
            return;
        end
        if (!enable) return;
        if (m_st[m] && m_cnt[m] < 64'hFFFF_FFFF) m_cnt[m]++;
        ins = issue_valid && !m_st[m] && !flush;
        for (int i = md[m] - 1; i >= 1; i--) mq[m][i] = mq[m][i-1];
        if (flush) mq[m][1].v = 0;
        mq[m][0] = '{ins && issue_reg_write && issue_rd != 0, int'(issue_rd), issue_mem_read};
        for (int s = 0; s < NS; s++) m_sel_q[m][s] = ins ? m_sel_c[m][s] : 0;
    endfunction

    task automatic drive(bit v, int rd, bit rw, bit ld, int s0, int s1, bit [1:0] used, bit fl);
        issue_valid     = v;
        issue_rd        = RW'(rd);
        issue_reg_write = rw;
        issue_mem_read  = ld;
        src_addr        = {RW'(s1), RW'(s0)};
        src_used        = used;
        flush           = fl;
    endtask

    task automatic step(string tag);
        @(negedge clk);
        mcompute(0);
        mcompute(1);
        last_stall_a = stall_a;
        last_stall_b = stall_b;
        chk({tag, "/stall_a"}, longint'(stall_a), longint'(m_st[0]));
        chk({tag, "/stall_b"}, longint'(stall_b), longint'(m_st[1]));
        @(posedge clk);
        mstep(0);
        mstep(1);
        #1;
        for (int s = 0; s < NS; s++) begin
            chk({tag, "/sel_a"}, longint'(fwd_sel_a[s*SWA +: SWA]), longint'(m_sel_q[0][s]));
            chk({tag, "/sel_b"}, longint'(fwd_sel_b[s*SWB +: SWB]), longint'(m_sel_q[1][s]));
        end
        chk({tag, "/cnt_a"}, longint'(cnt_a), m_cnt[0]);
        chk({tag, "/cnt_b"}, longint'(cnt_b), m_cnt[1]);
    endtask

    task automatic do_reset();
        srst = 1'b1;
        enable = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
        repeat (2) @(posedge clk);
        #1;
        srst = 1'b0;
        mreset(0);
        mreset(1);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_stall", longint'(stall_a), 0);
        chk("rst_sel", longint'(fwd_sel_a), 0);
        chk("rst_cnt", longint'(cnt_a), 0);
        chk("rst_cnt_b", longint'(cnt_b), 0);

        // add x5 ; sub x6,x5,x5
        drive(1, 5, 1, 0, 1, 2, 2'b11, 0); step("add");
        drive(1, 6, 1, 0, 5, 5, 2'b11, 0); step("sub");
        chk("sub_nostall", longint'(last_stall_a), 0);
        chk("sub_sel", longint'(fwd_sel_a), 10);

        // ld x7 ; add x8,x7,x1 : one-cycle load-use stall on the default unit
        do_reset();
        drive(1, 7, 1, 1, 3, 4, 2'b11, 0); step("ld");
        drive(1, 8, 1, 0, 7, 1, 2'b11, 0); step("lu1");
        chk("lu1_stall", longint'(last_stall_a), 1);
        chk("lu1_bubble", longint'(fwd_sel_a), 0);
        step("lu2");
        chk("lu2_stall", longint'(last_stall_a), 0);
        chk("lu2_sel", longint'(fwd_sel_a), 3);
        chk("lu2_cnt", longint'(cnt_a), 1);

        // x0 producer and consumer; unused source on a live match
        drive(1, 0, 1, 0, 1, 1, 2'b11, 0); step("x0p");
        drive(1, 3, 1, 0, 0, 0, 2'b11, 0); step("x0c");
        chk("x0_stall", longint'(last_stall_a), 0);
        chk("x0_sel", longint'(fwd_sel_a), 0);
        drive(1, 10, 1, 0, 1, 1, 2'b11, 0); step("unp");
        drive(1, 3, 1, 0, 10, 10, 2'b00, 0); step("unc");
        chk("unused_sel", longint'(fwd_sel_a), 0);

        // Two writers of x9, then a reader: youngest wins
        drive(1, 9, 1, 0, 1, 1, 2'b11, 0); step("w9a");
        drive(1, 9, 1, 0, 1, 1, 2'b11, 0); step("w9b");
        drive(1, 4, 1, 0, 9, 9, 2'b11, 0); step("r9");
        chk("young_sel", longint'(fwd_sel_a), 10);

        // Load in slot 0, reader in ID with flush in the same cycle
        drive(1, 11, 1, 1, 1, 1, 2'b11, 0); step("ldf");
        drive(1, 12, 1, 0, 11, 11, 2'b11, 1); step("fl");
        chk("flush_stall", longint'(last_stall_a), 0);
        chk("flush_sel", longint'(fwd_sel_a), 0);
        drive(1, 12, 1, 0, 11, 11, 2'b11, 0); step("afl");
        chk("afl_stall", longint'(last_stall_a), 0);
        chk("afl_sel", longint'(fwd_sel_a), 0);

        // Source naming its own rd uses the older producer
        drive(1, 13, 1, 0, 1, 1, 2'b11, 0); step("own_p");
        drive(1, 13, 1, 0, 13, 0, 2'b11, 0); step("own_c");
        chk("own_sel", longint'(fwd_sel_a[SWA-1:0]), 2);

        // Deep unit: two-cycle load-use stall with a 3-cycle freeze in the middle
        do_reset();
        drive(1, 7, 1, 1, 3, 4, 2'b11, 0); step("bld");
        drive(1, 8, 1, 0, 7, 1, 2'b11, 0); step("b_s1");
        chk("b_s1_stall", longint'(last_stall_b), 1);
        chk("b_s1_cnt", longint'(cnt_b), 1);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("b_frz");
            chk("b_frz_stall", longint'(last_stall_b), 1);
            chk("b_frz_cnt", longint'(cnt_b), 1);
        end
        enable = 1'b1;
        step("b_s2");
        chk("b_s2_stall", longint'(last_stall_b), 1);
        chk("b_s2_cnt", longint'(cnt_b), 2);
        step("b_go");
        chk("b_go_stall", longint'(last_stall_b), 0);
        chk("b_go_sel0", longint'(fwd_sel_b[SWB-1:0]), 4);
        chk("b_go_sel1", longint'(fwd_sel_b[2*SWB-1:SWB]), 0);
        chk("b_go_cnt", longint'(cnt_b), 2);

        // Randomized traffic over a small register window
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 9) != 0), $urandom_range(0, 7), $urandom_range(0, 1),
                  ($urandom_range(0, 2) == 0), $urandom_range(0, 7), $urandom_range(0, 7),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 11) == 0));
            enable = ($urandom_range(0, 9) != 0);
            srst   = ($urandom_range(0, 49) == 0);
            step("rnd");
        end
        srst = 1'b0;
        enable = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
